// File: rtl/pump_scheduler.sv
// Fill-cycle controller for the two-pump tank: debounced start, minimum run time,
// alternating lead pump, dual-pump run on critical level, fault substitution and alarm.
module pump_scheduler #(
  parameter int unsigned START_DLY = 4,
  parameter int unsigned MIN_ON    = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic lvl_lo,
  input  logic lvl_crit,
  input  logic lvl_hi,
  input  logic fault1,
  input  logic fault2,
  output logic pump1,
  output logic pump2,
  output logic lead,
  output logic alarm,
  output logic busy
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StDelay     = 3'd1;
  localparam logic [2:0] StRunSingle = 3'd2;
  localparam logic [2:0] StRunDual   = 3'd3;
  localparam logic [2:0] StFault     = 3'd4;

  localparam logic [CNT_W-1:0] DlyLoad = CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0] MinOn   = CNT_W'(MIN_ON);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             lead_d;
  logic             pump1_d, pump2_d;
  logic             sens_err, both_flt;

  assign sens_err = lvl_hi & (lvl_lo | lvl_crit);
  assign both_flt = fault1 & fault2;
  assign cnt_inc  = (cnt_q >= MinOn) ? MinOn : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lead_d  = lead;
    if (both_flt || sens_err) begin
      state_d = StFault;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (lvl_lo) begin
            state_d = StDelay;
            cnt_d   = DlyLoad;
          end
        end
        StDelay: begin
          if (!lvl_lo) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = lvl_crit ? StRunDual : StRunSingle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StRunSingle, StRunDual: begin
          if (lvl_hi && (cnt_q >= MinOn)) begin
            state_d = StIdle;
            cnt_d   = '0;
            lead_d  = ~lead;
          end else begin
            cnt_d = cnt_inc;
            if (lvl_crit) state_d = StRunDual;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Substitution picks the healthy pump without touching lead.
  always_comb begin
    pump1_d = 1'b0;
    pump2_d = 1'b0;
    if (state_d == StRunSingle) begin
      pump1_d = lead_d ? fault2 : ~fault1;
      pump2_d = lead_d ? ~fault2 : fault1;
    end else if (state_d == StRunDual) begin
      pump1_d = ~fault1;
      pump2_d = ~fault2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lead    <= 1'b0;
      pump1   <= 1'b0;
      pump2   <= 1'b0;
      alarm   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lead    <= lead_d;
      pump1   <= pump1_d;
      pump2   <= pump2_d;
      alarm   <= (state_d == StFault);
      busy    <= (state_d == StDelay) || (state_d == StRunSingle) || (state_d == StRunDual);
    end
  end

endmodule

// File: tb/tb_pump_scheduler.sv
// Bench for pump_scheduler: directed vector table, hand-written corner sequences and
// randomized traffic against an abstract fill-cycle model.
module tb_pump_scheduler;

  localparam int START_DLY = 4;
  localparam int MIN_ON    = 8;

  logic clk = 1'b0;
  logic reset, lvl_lo, lvl_crit, lvl_hi, fault1, fault2;
  logic pump1, pump2, lead, alarm, busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pump_scheduler #(.START_DLY(START_DLY), .MIN_ON(MIN_ON), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .lvl_lo(lvl_lo), .lvl_crit(lvl_crit), .lvl_hi(lvl_hi),
    .fault1(fault1), .fault2(fault2), .pump1(pump1), .pump2(pump2), .lead(lead),
    .alarm(alarm), .busy(busy)
  );

  typedef struct {
    string      name;
    logic       rst, lo, crit, hi, f1, f2;
    logic [4:0] exp;  // {pump1, pump2, lead, alarm, busy}
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, logic rst, logic lo, logic crit, logic hi,
                              logic f1, logic f2, logic [4:0] e);
    vec_t v;
    v.name = nm; v.rst = rst; v.lo = lo; v.crit = crit; v.hi = hi;
    v.f1 = f1; v.f2 = f2; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic rst, logic lo, logic crit, logic hi, logic f1, logic f2);
    reset = rst; lvl_lo = lo; lvl_crit = crit; lvl_hi = hi; fault1 = f1; fault2 = f2;
  endtask

  task automatic tick_check(string nm, logic [4:0] e);
    logic [4:0] act;
    @(posedge clk);
    #1;
    act = {pump1, pump2, lead, alarm, busy};
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got p1p2/lead/alarm/busy=%b expected %b", nm, act, e);
    end
  endtask

  // Abstract model: counts consecutive request edges and elapsed run edges.
  int m_mode;  // 0 idle, 1 waiting, 2 filling, 3 alarm
  int m_seen, m_elapsed;
  bit m_dual, m_lead;

  task automatic model_step(logic rst, logic lo, logic crit, logic hi, logic f1, logic f2);
    if (rst) begin
      m_mode = 0; m_lead = 0; m_dual = 0;
    end else if ((f1 && f2) || (hi && (lo || crit))) begin
      m_mode = 3;
    end else begin
      case (m_mode)
        0: if (lo) begin m_mode = 1; m_seen = 1; end
        1: begin
          if (!lo) m_mode = 0;
          else begin
            m_seen++;
            if (m_seen == START_DLY + 1) begin
              m_mode = 2; m_dual = crit; m_elapsed = 0;
            end
          end
        end
        2: begin
          if (hi && m_elapsed >= MIN_ON) begin
            m_mode = 0; m_lead = !m_lead;
          end else begin
            m_elapsed++;
            if (crit) m_dual = 1;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  function automatic logic [4:0] model_exp(logic f1, logic f2);
    logic p1, p2;
    p1 = 0; p2 = 0;
    if (m_mode == 2) begin
      if (m_dual) begin p1 = !f1; p2 = !f2; end
      else if (!m_lead) begin p1 = !f1; p2 = f1; end
      else begin p1 = f2; p2 = !f2; end
    end
    return {p1, p2, m_lead, m_mode == 3, m_mode == 1 || m_mode == 2};
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    // Directed table.
    add("reset", 1, 0, 0, 0, 0, 0, 5'b00000);
    add("pulse_dly", 0, 1, 0, 0, 0, 0, 5'b00001);
    add("pulse_dly", 0, 1, 0, 0, 0, 0, 5'b00001);
    add("pulse_drop", 0, 0, 0, 0, 0, 0, 5'b00000);
    add("idle", 0, 0, 0, 0, 0, 0, 5'b00000);
    for (int i = 0; i < START_DLY; i++) add("start_dly1", 0, 1, 0, 0, 0, 0, 5'b00001);
    add("start_p1", 0, 1, 0, 0, 0, 0, 5'b10001);
    for (int i = 0; i < MIN_ON; i++) add("run_p1", 0, 0, 0, 0, 0, 0, 5'b10001);
    add("stop_p1", 0, 0, 0, 1, 0, 0, 5'b00100);
    for (int i = 0; i < START_DLY; i++) add("start_dly2", 0, 1, 0, 0, 0, 0, 5'b00101);
    add("start_p2", 0, 1, 0, 0, 0, 0, 5'b01101);
    add("crit_dual", 0, 1, 1, 0, 0, 0, 5'b11101);
    for (int i = 0; i < MIN_ON - 1; i++) add("dual_hold", 0, 0, 0, 0, 0, 0, 5'b11101);
    add("dual_stop", 0, 0, 0, 1, 0, 0, 5'b00000);
    add("sens_err", 0, 1, 0, 1, 0, 0, 5'b00010);
    add("sens_clr", 0, 0, 0, 0, 0, 0, 5'b00000);
    add("both_flt", 0, 0, 0, 0, 1, 1, 5'b00010);
    add("flt_clr", 0, 0, 0, 0, 0, 0, 5'b00000);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lo, vecs[i].crit, vecs[i].hi, vecs[i].f1, vecs[i].f2);
      tick_check(vecs[i].name, vecs[i].exp);
    end

    // lvl_hi arrives before the minimum run time has elapsed.
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < START_DLY; i++) tick_check("min_dly", 5'b00001);
    tick_check("min_start", 5'b10001);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick_check("min_run", 5'b10001);
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < MIN_ON - 3; i++) tick_check("min_hold", 5'b10001);
    tick_check("min_stop", 5'b00100);

    // Reset mid-fill with lead=1.
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < START_DLY; i++) tick_check("rst_dly", 5'b00101);
    tick_check("rst_p2", 5'b01101);
    drive(1, 1, 0, 0, 0, 0);
    tick_check("rst_mid", 5'b00000);

    // Fault substitution then double fault.
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < START_DLY; i++) tick_check("sub_dly", 5'b00001);
    tick_check("sub_p1", 5'b10001);
    drive(0, 0, 0, 0, 1, 0);
    tick_check("sub_swap", 5'b01001);
    drive(0, 0, 0, 0, 1, 1);
    tick_check("sub_alarm", 5'b00010);
    drive(0, 0, 0, 0, 1, 0);
    tick_check("sub_clear", 5'b00000);

    // Randomized traffic against the model.
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    tick_check("rand_reset", model_exp(0, 0));
    for (int c = 0; c < 4000; c++) begin
      logic r, lo, cr, hi, f1, f2;
      r  = ($urandom_range(299) == 0);
      lo = ($urandom_range(7) == 0) ? !lvl_lo : lvl_lo;
      cr = lo && (($urandom_range(9) == 0) ? !lvl_crit : lvl_crit);
      if (lo) hi = ($urandom_range(60) == 0);
      else    hi = ($urandom_range(9) == 0) ? !lvl_hi : lvl_hi;
      f1 = ($urandom_range(40) == 0) ? !fault1 : fault1;
      f2 = ($urandom_range(40) == 0) ? !fault2 : fault2;
      drive(r, lo, cr, hi, f1, f2);
      model_step(r, lo, cr, hi, f1, f2);
      tick_check("random", model_exp(f1, f2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
